// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register: captures the decode control bundle and datapath fields,
// supports hold, bubble insertion with X-free control, and a saturating bubble counter.
module id_ex_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [1:0]       i_result_src,
  input  logic             i_mem_write,
  input  logic             i_reg_write,
  input  logic             i_jmp,
  input  logic             i_branch,
  input  logic [1:0]       i_alu_op,
  input  logic             i_alu_src,
  input  logic [XLEN-1:0]  i_rd1,
  input  logic [XLEN-1:0]  i_rd2,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [XLEN-1:0]  i_imm_ext,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7b5,
  output logic [1:0]       o_result_src,
  output logic             o_mem_write,
  output logic             o_reg_write,
  output logic             o_jmp,
  output logic             o_branch,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_src,
  output logic [XLEN-1:0]  o_rd1,
  output logic [XLEN-1:0]  o_rd2,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic [XLEN-1:0]  o_imm_ext,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [2:0]       o_funct3,
  output logic             o_funct7b5,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_bubble_count
);

  localparam int CTRL_W = 9;

  // Don't-care (X/Z) control bits from decode are forced to 0 so execute never sees X.
  function automatic logic [CTRL_W-1:0] sanitize_ctrl(input logic [CTRL_W-1:0] raw);
    logic [CTRL_W-1:0] clean;
    clean = {CTRL_W{1'b0}};
    for (int i = 0; i < CTRL_W; i++) begin
      clean[i] = (raw[i] === 1'b1) ? 1'b1 : 1'b0;
    end
    return clean;
  endfunction

  logic [CTRL_W-1:0] ctrl_in_s;
  logic              bubble_s;
  logic              capture_s;
  logic              cnt_sat_s;

  logic [CTRL_W-1:0] ctrl_r;
  logic              valid_r;
  logic [XLEN-1:0]   rd1_r;
  logic [XLEN-1:0]   rd2_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   pc_plus4_r;
  logic [XLEN-1:0]   imm_ext_r;
  logic [4:0]        rs1_r;
  logic [4:0]        rs2_r;
  logic [4:0]        rd_r;
  logic [2:0]        funct3_r;
  logic              funct7b5_r;
  logic [CNT_W-1:0]  cnt_r;

  assign ctrl_in_s = {i_result_src, i_mem_write, i_reg_write, i_jmp, i_branch, i_alu_op, i_alu_src};
  assign cnt_sat_s = &cnt_r;

  // Action select: flush beats stall; an invalid decode slot on capture becomes a bubble.
  always_comb begin
    bubble_s  = 1'b0;
    capture_s = 1'b0;
    if (i_flush) begin
      bubble_s = 1'b1;
    end else if (i_stall) begin
      bubble_s = 1'b0;
    end else if (i_valid) begin
      capture_s = 1'b1;
    end else begin
      bubble_s = 1'b1;
    end
  end

  // Pipeline state and bubble counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_r     <= {CTRL_W{1'b0}};
      valid_r    <= 1'b0;
      rd1_r      <= {XLEN{1'b0}};
      rd2_r      <= {XLEN{1'b0}};
      pc_r       <= {XLEN{1'b0}};
      pc_plus4_r <= {XLEN{1'b0}};
      imm_ext_r  <= {XLEN{1'b0}};
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      rd_r       <= 5'd0;
      funct3_r   <= 3'd0;
      funct7b5_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (bubble_s) begin
      ctrl_r     <= {CTRL_W{1'b0}};
      valid_r    <= 1'b0;
      rd1_r      <= {XLEN{1'b0}};
      rd2_r      <= {XLEN{1'b0}};
      pc_r       <= {XLEN{1'b0}};
      pc_plus4_r <= {XLEN{1'b0}};
      imm_ext_r  <= {XLEN{1'b0}};
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      rd_r       <= 5'd0;
      funct3_r   <= 3'd0;
      funct7b5_r <= 1'b0;
      if (!cnt_sat_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (capture_s) begin
      ctrl_r     <= sanitize_ctrl(ctrl_in_s);
      valid_r    <= 1'b1;
      rd1_r      <= i_rd1;
      rd2_r      <= i_rd2;
      pc_r       <= i_pc;
      pc_plus4_r <= i_pc_plus4;
      imm_ext_r  <= i_imm_ext;
      rs1_r      <= i_rs1;
      rs2_r      <= i_rs2;
      rd_r       <= i_rd;
      funct3_r   <= i_funct3;
      funct7b5_r <= i_funct7b5;
    end
  end

  assign o_result_src   = ctrl_r[8:7];
  assign o_mem_write    = ctrl_r[6];
  assign o_reg_write    = ctrl_r[5];
  assign o_jmp          = ctrl_r[4];
  assign o_branch       = ctrl_r[3];
  assign o_alu_op       = ctrl_r[2:1];
  assign o_alu_src      = ctrl_r[0];
  assign o_valid        = valid_r;
  assign o_rd1          = rd1_r;
  assign o_rd2          = rd2_r;
  assign o_pc           = pc_r;
  assign o_pc_plus4     = pc_plus4_r;
  assign o_imm_ext      = imm_ext_r;
  assign o_rs1          = rs1_r;
  assign o_rs2          = rs2_r;
  assign o_rd           = rd_r;
  assign o_funct3       = funct3_r;
  assign o_funct7b5     = funct7b5_r;
  assign o_bubble_count = cnt_r;

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed scenarios plus randomized traffic
// compared against a behavioural model of the register's contents and bubble count.
module tb_id_ex_register;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic i_clk, i_rst_n, i_stall, i_flush, i_valid;
  logic [1:0] i_result_src, i_alu_op;
  logic i_mem_write, i_reg_write, i_jmp, i_branch, i_alu_src, i_funct7b5;
  logic [XLEN-1:0] i_rd1, i_rd2, i_pc, i_pc_plus4, i_imm_ext;
  logic [4:0] i_rs1, i_rs2, i_rd;
  logic [2:0] i_funct3;

  logic [1:0] o_result_src, o_alu_op;
  logic o_mem_write, o_reg_write, o_jmp, o_branch, o_alu_src, o_funct7b5, o_valid;
  logic [XLEN-1:0] o_rd1, o_rd2, o_pc, o_pc_plus4, o_imm_ext;
  logic [4:0] o_rs1, o_rs2, o_rd;
  logic [2:0] o_funct3;
  logic [CNT_W-1:0] o_bubble_count;

  int tests = 0;
  int failed = 0;

  // Model: the instruction slot currently presented to execute, plus bubble count
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic [178:0] m_data;
  int          m_cnt;

  id_ex_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_result_src(i_result_src), .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_jmp(i_jmp), .i_branch(i_branch), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src),
    .i_rd1(i_rd1), .i_rd2(i_rd2), .i_pc(i_pc), .i_pc_plus4(i_pc_plus4), .i_imm_ext(i_imm_ext),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
    .o_result_src(o_result_src), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
    .o_jmp(o_jmp), .o_branch(o_branch), .o_alu_op(o_alu_op), .o_alu_src(o_alu_src),
    .o_rd1(o_rd1), .o_rd2(o_rd2), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_imm_ext(o_imm_ext),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3), .o_funct7b5(o_funct7b5),
    .o_valid(o_valid), .o_bubble_count(o_bubble_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 192'(o_valid), 192'(m_valid));
    check({tag, ".ctrl"},
          192'({o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch, o_alu_op, o_alu_src}),
          192'(m_ctrl));
    check({tag, ".data"},
          192'({o_rd1, o_rd2, o_pc, o_pc_plus4, o_imm_ext, o_rs1, o_rs2, o_rd, o_funct3, o_funct7b5}),
          192'(m_data));
    check({tag, ".count"}, 192'(o_bubble_count), 192'(m_cnt));
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_data = '0; m_cnt = 0;
  endtask

  // Apply the register's rules to the inputs present at this edge
  task automatic model_edge();
    logic [8:0] raw;
    raw = {i_result_src, i_mem_write, i_reg_write, i_jmp, i_branch, i_alu_op, i_alu_src};
    if (i_flush || (!i_stall && !i_valid)) begin
      m_valid = 1'b0; m_ctrl = '0; m_data = '0;
      if (m_cnt < CMAX) m_cnt = m_cnt + 1;
    end else if (!i_stall) begin
      m_valid = 1'b1;
      for (int b = 0; b < 9; b++) m_ctrl[b] = (raw[b] === 1'b1);
      m_data = {i_rd1, i_rd2, i_pc, i_pc_plus4, i_imm_ext, i_rs1, i_rs2, i_rd, i_funct3, i_funct7b5};
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic zero_inputs();
    i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_result_src = 2'b00; i_mem_write = 1'b0; i_reg_write = 1'b0; i_jmp = 1'b0;
    i_branch = 1'b0; i_alu_op = 2'b00; i_alu_src = 1'b0;
    i_rd1 = 32'd0; i_rd2 = 32'd0; i_pc = 32'd0; i_pc_plus4 = 32'd0; i_imm_ext = 32'd0;
    i_rs1 = 5'd0; i_rs2 = 5'd0; i_rd = 5'd0; i_funct3 = 3'd0; i_funct7b5 = 1'b0;
  endtask

  task automatic rand_fields();
    i_result_src = 2'($urandom); i_mem_write = 1'($urandom); i_reg_write = 1'($urandom);
    i_jmp = 1'($urandom); i_branch = 1'($urandom); i_alu_op = 2'($urandom);
    i_alu_src = 1'($urandom);
    i_rd1 = $urandom; i_rd2 = $urandom; i_pc = $urandom; i_pc_plus4 = i_pc + 32'd4;
    i_imm_ext = $urandom; i_rs1 = 5'($urandom); i_rs2 = 5'($urandom); i_rd = 5'($urandom);
    i_funct3 = 3'($urandom); i_funct7b5 = 1'($urandom);
  endtask

  initial begin
    zero_inputs();
    i_rst_n = 1'b0;
    model_reset();
    #12;
    check_all("por");

    // Asynchronous reset with busy inputs, mid-cycle, no edge needed
    i_rst_n = 1'b1;
    rand_fields(); i_valid = 1'b1;
    tick();
    check_all("pre_reset_capture");
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Capture addi
    zero_inputs();
    i_valid = 1'b1; i_reg_write = 1'b1; i_alu_src = 1'b1;
    i_rd1 = 32'h0000_0010; i_imm_ext = 32'h0000_0005; i_rd = 5'd3;
    tick();
    check_all("addi");
    check("addi.rd", 192'(o_rd), 192'(5'd3));
    check("addi.count0", 192'(o_bubble_count), 192'(0));

    // Stall hold for three edges while inputs change
    for (int k = 0; k < 3; k++) begin
      rand_fields(); i_valid = 1'($urandom); i_stall = 1'b1;
      tick();
      check_all("stall_hold");
      check("stall.imm", 192'(o_imm_ext), 192'(32'h0000_0005));
    end

    // Flush and stall together with a valid sw bundle
    zero_inputs();
    i_valid = 1'b1; i_mem_write = 1'b1; i_rd = 5'd7; i_stall = 1'b1; i_flush = 1'b1;
    tick();
    check_all("flush_over_stall");
    check("flush.count", 192'(o_bubble_count), 192'(1));

    // Don't-care result_src on a sw
    zero_inputs();
    i_valid = 1'b1; i_mem_write = 1'b1; i_result_src = 2'bxx; i_rd2 = 32'hDEAD_BEEF;
    tick();
    check_all("xsan");
    check("xsan.known", 192'($isunknown({o_result_src, o_mem_write, o_reg_write, o_jmp, o_branch,
                                         o_alu_op, o_alu_src, o_valid, o_rd1, o_rd2})), 192'(0));
    check("xsan.mem_write", 192'(o_mem_write), 192'(1));

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rand_fields();
      i_valid = ($urandom_range(3) != 0);
      i_stall = ($urandom_range(3) == 0);
      i_flush = ($urandom_range(7) == 0);
      tick();
      check_all("random");
    end

    // Reset during a stall discards the held instruction
    zero_inputs();
    rand_fields(); i_valid = 1'b1;
    tick();
    i_stall = 1'b1;
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    i_rst_n = 1'b1;
    tick();
    check_all("reset_mid_stall");
    check("reset_mid_stall.valid", 192'(o_valid), 192'(0));

    // Counter saturation: 20 invalid slots
    zero_inputs();
    for (int k = 1; k <= 20; k++) begin
      rand_fields(); i_valid = 1'b0;
      tick();
      check("sat.count", 192'(o_bubble_count), 192'((k < CMAX) ? k : CMAX));
      check_all("sat");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
